dual_issue_queue: RTL

//  Two-wide in-order FIFO between decode and the issue unit. Accepts up to two decoded uops per cycle.

---
 rtl/issue_pkg.sv | 37 +++
 rtl/pair_hazard_check.sv | 24 ++
 rtl/dual_issue_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - decoded uop type and pairing classification helpers for the dual issue queue
package issue_pkg;

    localparam int WIDTH     = 32;
    localparam int ALU_OP    = 4;
    localparam int LOAD_TYPE = 3;

    typedef struct packed {
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [WIDTH-1:0]     pc;
        logic [WIDTH-1:0]     imm;
        logic                 imm_en;
        logic [4:0]           shift;
        logic [ALU_OP-1:0]    alu_op;
        logic                 rf_we;
        logic                 mem_rd;
        logic                 mem_wr;
        logic [LOAD_TYPE-1:0] load_type;
        logic [1:0]           store_type;
        logic                 branch;
        logic                 jal;
        logic                 jalr;
        logic                 uses_rs1;
        logic                 uses_rs2;
    } issue_uop_t;

    function automatic logic is_mem(input issue_uop_t u);
        return (u.load_type != '0) || (u.store_type != '0);
    endfunction

    function automatic logic is_ctrl(input issue_uop_t u);
        return u.branch | u.jal | u.jalr;
    endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// rtl/pair_hazard_check.sv - flags a slot0/slot1 pair that must not issue together
module pair_hazard_check
    import issue_pkg::*;
(
    input  issue_uop_t s0,
    input  issue_uop_t s1,
    output logic       pair_hazard
);

    logic raw;
    logic unused_fields;

    // x0 writes are architecturally discarded, so they never create a dependency
    assign raw = s0.rf_we && (s0.rd != 5'd0) &&
                 ((s1.uses_rs1 && (s1.rs1 == s0.rd)) ||
                  (s1.uses_rs2 && (s1.rs2 == s0.rd)));

    assign pair_hazard = (is_mem(s0) && is_mem(s1)) ||
                         (is_ctrl(s0) && is_ctrl(s1)) ||
                         raw;

    assign unused_fields = ^{s0, s1};

endmodule

// File: rtl/dual_issue_queue.sv
// rtl/dual_issue_queue.sv - two-wide in-order decode-to-issue FIFO with pair splitting
// Optional zero-latency empty-queue bypass enabled by defining ISSUE_QUEUE_BYPASS_EN.
module dual_issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [1:0]             in_valid,
    input  issue_uop_t [1:0]       in_uop,
    output logic                   in_ready,
    output logic [1:0]             out_valid,
    output issue_uop_t [1:0]       out_uop,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    issue_uop_t     mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr1;
    logic [PW-1:0]  rd_ptr1;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [CW:0]    cnt_plus;

    logic [1:0]     enq_n;
    logic [1:0]     wr_n;
    logic [1:0]     deq_n;
    logic [1:0]     consumed;
    logic           wr_skip;
    logic           byp;
    logic           pair_hazard;
    logic           s1_present;
    issue_uop_t     s0;
    issue_uop_t     s1;
    issue_uop_t     wdat0;

    assign in_ready  = count <= CW'(DEPTH - 2);
    assign occupancy = count;
    assign rd_ptr1   = rd_ptr + 1'b1;
    assign wr_ptr1   = wr_ptr + 1'b1;

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign byp = (count == '0) && !flush && in_ready && in_valid[0];
`else
    assign byp = 1'b0;
`endif

    // Candidate pair: incoming uops when bypassing, otherwise the two oldest entries
    always_comb begin
        s0         = mem[rd_ptr];
        s1         = mem[rd_ptr1];
        s1_present = count >= CW'(2);
        if (byp) begin
            s0         = in_uop[0];
            s1         = in_uop[1];
            s1_present = in_valid[1];
        end
    end

    pair_hazard_check u_hazard (
        .s0          (s0),
        .s1          (s1),
        .pair_hazard (pair_hazard)
    );

    assign out_valid[0] = byp || (count != '0);
    assign out_valid[1] = s1_present && !pair_hazard;
    assign out_uop[0]   = s0;
    assign out_uop[1]   = s1;

    always_comb begin
        enq_n    = 2'd0;
        wr_n     = 2'd0;
        deq_n    = 2'd0;
        wr_skip  = 1'b0;
        consumed = out_ready ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;
        if (in_ready && in_valid[0]) begin
            enq_n = in_valid[1] ? 2'd2 : 2'd1;
        end
        if (byp) begin
            // Consumed bypass uops never enter storage; a split pair stores only slot1
            wr_n    = enq_n - consumed;
            wr_skip = consumed != 2'd0;
        end else begin
            wr_n  = enq_n;
            deq_n = consumed;
        end
        wdat0      = wr_skip ? in_uop[1] : in_uop[0];
        cnt_plus   = {1'b0, count} + (CW+1)'(wr_n);
        count_next = count + CW'(wr_n) - CW'(deq_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_n != 2'd0) begin
                mem[wr_ptr] <= wdat0;
            end
            if (wr_n == 2'd2) begin
                mem[wr_ptr1] <= in_uop[1];
            end
            wr_ptr <= wr_ptr + PW'(wr_n);
            rd_ptr <= rd_ptr + PW'(deq_n);
            count  <= count_next;
        end
    end

    a_no_bad_valid: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid != 2'b10);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_plus >= (CW+1)'(deq_n));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (cnt_plus - (CW+1)'(deq_n)) <= (CW+1)'(DEPTH));

endmodule
